ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter SIZE, default 14, meaning RAM address width.
REQ-002 Parameter DEPTH, default 1024, meaning RAM word count; informational, not used in logic.
REQ-003 Parameter MAX_BURST, default 8, meaning max consecutive granted cycles while the other master waits; legal range 2..255.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset; one clock, synchronous, active-low (rst==0 resets).
REQ-006 Ports m0_req, m1_req  input  1 each  access request, held until granted.
REQ-007 Ports m0_we, m1_we  input  1 each  1=write, 0=read.
REQ-008 Ports m0_addr, m1_addr  input  SIZE each  word address.
REQ-009 Ports m0_wdata, m1_wdata  input  32 each  write data.
REQ-010 Ports m0_gnt, m1_gnt  output  1 each  access accepted this cycle.
REQ-011 Ports m0_rvalid, m1_rvalid  output  1 each  read data valid.
REQ-012 Ports m0_rdata, m1_rdata  output  32 each  read data, both driven from ram_rdata.
REQ-013 Ports ram_we / ram_addr / ram_wdata  output  1 / SIZE / 32  to single-port RAM (i_we, i_addr, i_ram_data_in).
REQ-014 Port ram_rdata  input  32  RAM registered output, valid one cycle after read address.

Function
REQ-015 State machine states IDLE, OWN0, OWN1; registered burst counter cnt (8 bit); registered last-served bit last.
REQ-016 Grant is combinational from state, cnt, last, m0_req, m1_req; at most one gnt high per cycle.
REQ-017 IDLE: single requester granted; both requesting -> master != last granted.
REQ-018 OWNx: grant x if x_req and (cnt < MAX_BURST-1 or other not requesting); else grant other if requesting; else no grant.
REQ-019 Next state: OWNx when x granted, IDLE when no grant; last <= granted master index.
REQ-020 cnt: 0 on grant to different master or IDLE; cnt+1 when same owner granted again; saturates at MAX_BURST-1.
REQ-021 RAM mux: granted master's we/addr/wdata drive RAM same cycle; no grant -> ram_we=0, ram_addr=0, ram_wdata=0.
REQ-022 A read granted in cycle N -> x_rvalid=1 in cycle N+1 only, x_rdata=ram_rdata in N+1.
REQ-023 Granted writes produce no rvalid; write completes in grant cycle.
REQ-024 Back-to-back reads from alternating masters each get exactly one rvalid, in grant order, one per cycle.
REQ-025 Requester dropping req while granted (same cycle as gnt) is legal; arbiter re-evaluates next cycle with no penalty.
REQ-026 Worst-case wait for a requesting master: MAX_BURST cycles.

Reset
REQ-027 While rst==0 at a clock edge: state IDLE, cnt=0, last=1 (m0 wins first tie), rvalid pipeline cleared.
REQ-028 During rst==0 all gnt=0, ram_we=0, ram_addr=0, ram_wdata=0 regardless of requests.
REQ-029 Reset mid-burst or with a read outstanding: no rvalid issued in the cycle after reset deasserts.

Verification
REQ-030 Reset then m0_req=1 read addr 0x005 alone -> m0_gnt=1 same cycle, ram_addr=0x005, m0_rvalid=1 next cycle with RAM[5].
REQ-031 m0,m1 request simultaneously from IDLE after reset -> m0 granted first; repeated tie after IDLE -> m1 granted.
REQ-032 m0 holds req continuously, m1 requests from cycle 0 -> m0 granted cycles 0..7 (MAX_BURST=8), m1 granted cycle 8.
REQ-033 m0 write 0xDEADBEEF to 0x010, then m1 read 0x010 -> m1_rvalid=1 with 0xDEADBEEF, m0_rvalid never asserted.
REQ-034 Alternating reads m0@0x001, m1@0x002 on consecutive grants -> rvalids on consecutive cycles, each to correct master with correct data.
REQ-035 rst=0 asserted the cycle after a m1 read grant -> m1_rvalid=0 throughout, gnt=0 and ram_we=0 while rst=0.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-master arbiter in front of a single-port synchronous RAM.
//             Grants are combinational. Fairness combines a last-served
//             tie-break with a bounded burst counter, so a waiting master is
//             served within MAX_BURST cycles. Read data comes back one cycle
//             after the grant, tagged to the master that issued the read.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     : single clock, rising edge
//    rst                     : synchronous reset, active low
//    m0_req / m1_req         : access request, held until granted
//    m0_we / m1_we           : 1 = write, 0 = read
//    m0_addr / m1_addr       : word address (SIZE bits)
//    m0_wdata / m1_wdata     : write data (32 bits)
//    m0_gnt / m1_gnt         : access accepted this cycle
//    m0_rvalid / m1_rvalid   : read data valid for that master
//    m0_rdata / m1_rdata     : read data, both driven from ram_rdata
//    ram_we/ram_addr/ram_wdata : RAM command port
//    ram_rdata               : RAM registered read data (1-cycle latency)
// ============================================================================
module ram_arbiter #(
  parameter int SIZE      = 14,
  parameter int DEPTH     = 1024,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [SIZE-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [SIZE-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [31:0]     m0_rdata,
  output logic [31:0]     m1_rdata,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
);

  // Elaboration-time sanity checks on the parameter set.
  if ((MAX_BURST < 2) || (MAX_BURST > 255)) begin : g_burst_range_check
    $error("ram_arbiter: MAX_BURST must be within 2..255");
  end
  if ((SIZE < 31) && (DEPTH > (1 << SIZE))) begin : g_depth_check
    $error("ram_arbiter: DEPTH exceeds the SIZE-bit address space");
  end

  // Last burst count value at which the owner may still keep the RAM.
  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        last_q,  last_d;
  // One bit per master: a read was granted in the previous cycle.
  logic [1:0]  rvalid_q, rvalid_d;

  logic        gnt0;
  logic        gnt1;

  // --------------------------------------------------------------------------
  // Grant decision. Everything is masked while reset is asserted so the RAM
  // sees no command and no master believes it was accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            // Tie: serve whichever master was not served last.
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
          end else if (m0_req) begin
            gnt0 = 1'b1;
          end else if (m1_req) begin
            gnt1 = 1'b1;
          end
        end
        OWN0: begin
          // Owner keeps the RAM until its burst budget runs out, but only
          // when the other master is actually waiting.
          if (m0_req && ((cnt_q < CNT_MAX) || !m1_req)) gnt0 = 1'b1;
          else if (m1_req)                              gnt1 = 1'b1;
        end
        OWN1: begin
          if (m1_req && ((cnt_q < CNT_MAX) || !m0_req)) gnt1 = 1'b1;
          else if (m0_req)                              gnt0 = 1'b1;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next state, burst counter, last-served bit and read-return pipeline.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = IDLE;
    cnt_d    = 8'd0;
    last_d   = last_q;
    rvalid_d = 2'b00;

    if (gnt0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      // Counter only advances on a repeat grant to the current owner; the
      // saturation keeps it from wrapping while a lone requester streams.
      if (state_q == OWN0) begin
        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : (cnt_q + 8'd1);
      end
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      if (state_q == OWN1) begin
        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : (cnt_q + 8'd1);
      end
    end

    rvalid_d[0] = gnt0 && !m0_we;
    rvalid_d[1] = gnt1 && !m1_we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      last_q   <= 1'b1;       // m0 wins the first tie after reset
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. rvalid is qualified with rst so that a read granted just before
  // reset asserts never reports data in a cycle where reset is held.
  // --------------------------------------------------------------------------
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid_q[0] & rst;
  assign m1_rvalid = rvalid_q[1] & rst;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  // RAM command mux: idle bus is driven to all zeros.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = 32'd0;
    if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter. A behavioural RAM with a
//             registered read port sits behind the arbiter. Each stimulus
//             record carries the expected grants; expected read returns are
//             queued at the grant and compared one cycle later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.SIZE(AW), .DEPTH(1024), .MAX_BURST(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM, read-first, registered output.
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] exp_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  typedef struct {
    logic          rst;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic          g0, g1;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  function automatic vec_t mk(logic rs, logic r0, logic w0, logic [AW-1:0] a0,
                              logic [31:0] d0, logic r1, logic w1,
                              logic [AW-1:0] a1, logic [31:0] d1,
                              logic g0, logic g1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and read returns,
  // then update the scoreboard and the shadow memory.
  task automatic step(input vec_t v);
    sb_t           e;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    @(negedge clk);
    rst    = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    #2;
    // A reset cycle cancels any outstanding read return.
    if (!v.rst) sb_q.delete();
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.m == 0 ? "m0_rvalid" : "m1_rvalid", e.m == 0 ? {31'd0, m0_rvalid} : {31'd0, m1_rvalid}, 32'd1);
      chk(e.m == 0 ? "m1_rvalid_idle" : "m0_rvalid_idle", e.m == 0 ? {31'd0, m1_rvalid} : {31'd0, m0_rvalid}, 32'd0);
      chk(e.m == 0 ? "m0_rdata" : "m1_rdata", e.m == 0 ? m0_rdata : m1_rdata, e.data);
    end else begin
      chk("m0_rvalid_idle", {31'd0, m0_rvalid}, 32'd0);
      chk("m1_rvalid_idle", {31'd0, m1_rvalid}, 32'd0);
    end
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, v.g0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, v.g1});

    exp_we = 1'b0; exp_addr = '0; exp_wdata = 32'd0;
    if (v.g0) begin
      exp_we = v.w0; exp_addr = v.a0; exp_wdata = v.d0;
    end else if (v.g1) begin
      exp_we = v.w1; exp_addr = v.a1; exp_wdata = v.d1;
    end
    chk("ram_we",    {31'd0, ram_we},      {31'd0, exp_we});
    chk("ram_addr",  {18'd0, ram_addr},    {18'd0, exp_addr});
    chk("ram_wdata", ram_wdata,            exp_wdata);

    if (v.g0 || v.g1) begin
      if (exp_we) begin
        exp_mem[exp_addr] = exp_wdata;
      end else begin
        e.m = v.g0 ? 0 : 1;
        e.data = exp_mem[exp_addr];
        sb_q.push_back(e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'hC0DE_0000 | i;
      exp_mem[i] = 32'hC0DE_0000 | i;
    end
    rst = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    //            rst r0 w0 a0      d0             r1 w1 a1      d1            g0 g1
    // Reset held with both masters requesting: nothing may be granted.
    vecs.push_back(mk(0, 1, 1, 14'h007, 32'h1111_1111, 1, 1, 14'h008, 32'h2222_2222, 0, 0));
    vecs.push_back(mk(0, 1, 0, 14'h005, 32'h0,         1, 0, 14'h002, 32'h0,         0, 0));
    // First tie after reset goes to m0; read of 0x005.
    vecs.push_back(mk(1, 1, 0, 14'h005, 32'h0,         1, 0, 14'h002, 32'h0,         1, 0));
    // Nobody requests: back to IDLE, m0 read returns.
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         0, 0, 14'h000, 32'h0,         0, 0));
    // Repeated tie from IDLE: m1 now wins.
    vecs.push_back(mk(1, 1, 0, 14'h001, 32'h0,         1, 0, 14'h002, 32'h0,         0, 1));
    // m1 drops the cycle after its grant; m0 served, alternating reads.
    vecs.push_back(mk(1, 1, 0, 14'h001, 32'h0,         0, 0, 14'h000, 32'h0,         1, 0));
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         1, 0, 14'h001, 32'h0,         0, 1));
    // m0 writes DEADBEEF to 0x010, m1 reads it back.
    vecs.push_back(mk(1, 1, 1, 14'h010, 32'hDEAD_BEEF, 0, 0, 14'h000, 32'h0,         1, 0));
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         1, 0, 14'h010, 32'h0,         0, 1));
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         0, 0, 14'h000, 32'h0,         0, 0));
    // m1 writes, m0 reads the same word.
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         1, 1, 14'h020, 32'h1234_5678, 0, 1));
    vecs.push_back(mk(1, 1, 0, 14'h020, 32'h0,         0, 0, 14'h000, 32'h0,         1, 0));
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         0, 0, 14'h000, 32'h0,         0, 0));
    // m1 read granted, then reset asserted before its return.
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         1, 0, 14'h003, 32'h0,         0, 1));
    vecs.push_back(mk(0, 1, 1, 14'h030, 32'hAAAA_5555, 1, 1, 14'h031, 32'h5555_AAAA, 0, 0));
    vecs.push_back(mk(0, 0, 0, 14'h000, 32'h0,         1, 0, 14'h003, 32'h0,         0, 0));
    // First cycle out of reset: no stale return.
    vecs.push_back(mk(1, 0, 0, 14'h000, 32'h0,         0, 0, 14'h000, 32'h0,         0, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Burst fairness with both masters streaming reads: m0 owns cycles
    // 0..7, m1 owns 8..15, m0 takes over again at 16.
    for (int i = 0; i <= 16; i++) begin
      step(mk(1, 1, 0, AW'(i), 32'h0, 1, 0, AW'(14'h100 + i), 32'h0,
              (i < 8) || (i == 16), (i >= 8) && (i < 16)));
    end
    // Lone requester keeps the RAM past the burst limit.
    for (int i = 0; i < 10; i++) begin
      step(mk(1, 1, 0, AW'(14'h200 + i), 32'h0, 0, 0, 14'h000, 32'h0, 1, 0));
    end
    // Drain the last read return.
    step(mk(1, 0, 0, 14'h000, 32'h0, 0, 0, 14'h000, 32'h0, 0, 0));
    step(mk(1, 0, 0, 14'h000, 32'h0, 0, 0, 14'h000, 32'h0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
